// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared mode constants and default sizes for the sequence detector
package seq_det_pkg;

  localparam logic SEQ_MODE_FRAMED  = 1'b0;
  localparam logic SEQ_MODE_SLIDING = 1'b1;

  localparam int SEQ_DEFAULT_WIDTH = 6;
  localparam int SEQ_DEFAULT_CNT_W = 16;

endpackage

// File: rtl/seq_det_window.sv
// rtl/seq_det_window.sv - serial shift window with saturating fill count
module seq_det_window #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             data,
  output logic [WIDTH-1:0] window_next,
  output logic             full_next
);

  localparam int FILL_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  sr;
  logic [FILL_W-1:0] fill;

  // Oldest bit sits at sr[0]; the incoming bit enters at the top.
  assign window_next = {data, sr[WIDTH-1:1]};
  assign full_next   = (fill >= FILL_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      fill <= '0;
    end else if (clear) begin
      sr   <= '0;
      fill <= '0;
    end else if (shift) begin
      sr <= window_next;
      if (fill != FILL_W'(WIDTH))
        fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - framed/sliding serial pattern detector with saturating match count
// Optional per-bit don't-care mask enabled by defining SEQ_DET_MASK_EN.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int WIDTH = SEQ_DEFAULT_WIDTH,
  parameter int CNT_W = SEQ_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_data,
  input  logic             mode,
  input  logic [WIDTH-1:0] cfg_pattern,
`ifdef SEQ_DET_MASK_EN
  input  logic [WIDTH-1:0] cfg_mask,
`endif
  output logic             match,
  output logic             not_match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int POS_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] window_next;
  logic             full_next;
  logic [WIDTH-1:0] diff;
  logic [POS_W-1:0] pos;
  logic             frame_end;
  logic             eval;
  logic             hit;
  logic             miss;

  seq_det_window #(.WIDTH(WIDTH)) u_window (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .shift       (in_valid),
    .data        (in_data),
    .window_next (window_next),
    .full_next   (full_next)
  );

`ifdef SEQ_DET_MASK_EN
  assign diff = (window_next ^ cfg_pattern) & ~cfg_mask;
`else
  assign diff = window_next ^ cfg_pattern;
`endif

  assign frame_end = (pos == POS_W'(WIDTH - 1));
  // clear discards a coincident bit, so it also suppresses evaluation.
  assign eval = in_valid && !clear &&
                ((mode == SEQ_MODE_SLIDING) ? full_next : frame_end);
  assign hit  = eval && (diff == '0);
  assign miss = eval && (diff != '0) && (mode == SEQ_MODE_FRAMED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos       <= '0;
      match     <= 1'b0;
      not_match <= 1'b0;
      match_cnt <= '0;
    end else if (clear) begin
      pos       <= '0;
      match     <= 1'b0;
      not_match <= 1'b0;
      match_cnt <= '0;
    end else begin
      match     <= hit;
      not_match <= miss;
      if (hit && (match_cnt != '1))
        match_cnt <= match_cnt + CNT_W'(1);
      if (in_valid && (mode == SEQ_MODE_FRAMED))
        pos <= frame_end ? '0 : pos + POS_W'(1);
    end
  end

endmodule
